// File: rtl/gt_spi_engine.sv
// gt_spi_engine: register-mapped SPI byte shifter for the Gigatron extension board.
// The host loads DATA to start a transfer, polls STATUS/BUSY, then reads the received byte.
// It supports programmable chip selects, an SCK divider, CPOL/CPHA modes, LSB-first order
// and overrun flagging.
module gt_spi_engine #(
    parameter int unsigned NSS  = 2,
    parameter int unsigned DIVW = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR,
    input  logic             RD,
    input  logic [1:0]       ADDR,
    input  logic [7:0]       WDATA,
    output logic [7:0]       RDATA,
    output logic             BUSY,
    output logic             SCK,
    output logic             MOSI,
    output logic [NSS-1:0]   nSS,
    input  logic [NSS:0]     MISO
);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_DIV  = 2'd1;
    localparam logic [1:0] A_DATA = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic            cpol;
    logic            cpha;
    logic            lsbf;
    logic [DIVW-1:0] div_q;
    logic [DIVW-1:0] div_cnt;
    logic [4:0]      edge_cnt;
    logic [7:0]      tx_q;
    logic [7:0]      rx_sh;
    logic [7:0]      rx_q;
    logic            done;
    logic            ovr;

    logic            misox;
    logic [4:0]      edge_next;
    logic            tick;
    logic            leading;
    logic            last_edge;
    logic            sample;
    logic            shift_out;
    logic [2:0]      pos;
    logic            next_bit;
    logic [7:0]      rx_asm;

    // Selected slave's data; the default line is used only when no select is active
    always_comb begin
        misox = (MISO[NSS] & (&nSS)) | (|(MISO[NSS-1:0] & ~nSS));
    end

    // Edge classification, next outgoing bit and assembled receive byte
    always_comb begin
        edge_next = edge_cnt + 5'd1;
        tick      = (div_cnt == '0);
        leading   = edge_next[0];
        last_edge = edge_next[4];
        sample    = leading ^ cpha;
        shift_out = ~sample & ~last_edge;
        // CPHA=1 shifts on leading edge k -> bit (k-1)/2; CPHA=0 on trailing edge k -> bit k/2
        pos       = cpha ? edge_cnt[3:1] : edge_next[3:1];
        next_bit  = lsbf ? tx_q[pos] : tx_q[3'd7 - pos];
        rx_asm    = lsbf ? {misox, rx_sh[7:1]} : {rx_sh[6:0], misox};
    end

    // Register file, transfer FSM and SPI pin drivers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            nSS      <= '1;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
            lsbf     <= 1'b0;
            div_q    <= DIVW'(3);
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_q     <= '0;
            rx_sh    <= '0;
            rx_q     <= '0;
            done     <= 1'b0;
            ovr      <= 1'b0;
            BUSY     <= 1'b0;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
        end else begin
            if (WR && ADDR == A_STAT && WDATA[2]) begin
                ovr <= 1'b0;
            end
            if (RD && ADDR == A_DATA) begin
                done <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    SCK <= cpol;
                    if (WR) begin
                        case (ADDR)
                            A_CTRL: begin
                                nSS  <= WDATA[NSS-1:0];
                                cpol <= WDATA[4];
                                cpha <= WDATA[5];
                                lsbf <= WDATA[6];
                            end
                            A_DIV: begin
                                div_q <= WDATA[DIVW-1:0];
                            end
                            A_DATA: begin
                                state    <= S_SHIFT;
                                BUSY     <= 1'b1;
                                tx_q     <= WDATA;
                                rx_sh    <= '0;
                                edge_cnt <= '0;
                                div_cnt  <= div_q;
                                MOSI     <= lsbf ? WDATA[0] : WDATA[7];
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_SHIFT: begin
                    if (WR && ADDR != A_STAT) begin
                        ovr <= 1'b1;
                    end
                    if (tick) begin
                        div_cnt  <= div_q;
                        SCK      <= ~SCK;
                        edge_cnt <= edge_next;
                        if (sample) begin
                            rx_sh <= rx_asm;
                        end
                        if (shift_out) begin
                            MOSI <= next_bit;
                        end
                        if (last_edge) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                            rx_q  <= sample ? rx_asm : rx_sh;
                            // Completion overrides a same-cycle DATA read
                            done  <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIVW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Register read mux
    always_comb begin
        RDATA = 8'h00;
        case (ADDR)
            A_CTRL:  RDATA = {1'b0, lsbf, cpha, cpol, 4'(nSS)};
            A_DIV:   RDATA = 8'(div_q);
            A_DATA:  RDATA = rx_q;
            A_STAT:  RDATA = {5'b0, ovr, done, BUSY};
            default: RDATA = 8'h00;
        endcase
    end

endmodule
